// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
//   Bundles the fetch port, the load/store port, the unified memory port
//   and the busy flag of the memory arbiter.
//   slave  : the arbiter's view. It takes requests and memory read data, and
//            drives grants, done pulses, read data, the memory bus and busy.
//   master : the surrounding system's view. It is the opposite direction of
//            every signal (requesters plus the memory model).
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Fetch requester
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_gnt;
    logic              i_done;
    logic [DATA_W-1:0] i_rdata;
    // Load/store requester
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_done;
    logic [DATA_W-1:0] d_rdata;
    // Unified memory port
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_dataIn;
    logic              mem_wEn;
    logic [DATA_W-1:0] mem_memout;
    // Status
    logic              busy;

    modport slave (
        input  i_req, i_addr,
        input  d_req, d_we, d_addr, d_wdata,
        input  mem_memout,
        output i_gnt, i_done, i_rdata,
        output d_gnt, d_done, d_rdata,
        output mem_address, mem_dataIn, mem_wEn,
        output busy
    );

    modport master (
        output i_req, i_addr,
        output d_req, d_we, d_addr, d_wdata,
        output mem_memout,
        input  i_gnt, i_done, i_rdata,
        input  d_gnt, d_done, d_rdata,
        input  mem_address, mem_dataIn, mem_wEn,
        input  busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   This block shares the single port of the unified instruction/data memory
//   between the fetch requester (i_*) and the load/store requester (d_*).
//   The winner is chosen in IDLE and granted in that same cycle. The access
//   then stays in ACCESS for 1+WAIT_STATES cycles, and the owner's done pulse
//   appears in the following IDLE cycle.
//
// Handshake: a requester holds req (with its address/data) until it sees gnt
//   high at a clock edge. gnt is a same-cycle acceptance, so a req still high
//   in the cycle after gnt is a new request. The done pulse lasts exactly one
//   cycle, and i_rdata/d_rdata are only meaningful while it is high.
//
// Ports
//   clk          system clock, all state on posedge
//   rst          asynchronous active-high reset
//   bus          mem_arbiter_if.slave: fetch port, data port, memory port, busy
//   dbg_state_o  FSM state, 0 = IDLE, 1 = ACCESS
module mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int WAIT_STATES  = 1,
    parameter int STARVE_LIMIT = 2
) (
    input  logic           clk,
    input  logic           rst,
    mem_arbiter_if.slave   bus,
    output logic           dbg_state_o
);

    localparam int SCNT_W = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SCNT_W-1:0] SCNT_LIM = SCNT_W'(STARVE_LIMIT);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t              state_q;
    logic                owner_d_q;  // 1 = load/store owns the access, 0 = fetch
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                we_q;       // only ever set for a data-port store
    logic [3:0]          cnt_q;
    logic [SCNT_W-1:0]   scnt_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                i_done_q;
    logic                d_done_q;

    logic                fetch_win;
    logic                data_win;
    logic                last_cycle;

    // Data wins by default. Fetch wins when it is alone, or when data has
    // already won STARVE_LIMIT times in a row while fetch was waiting.
    always_comb begin
        fetch_win  = bus.i_req && (!bus.d_req || (scnt_q >= SCNT_LIM));
        data_win   = bus.d_req && !fetch_win;
        last_cycle = (state_q == ACCESS) && (cnt_q == 4'd0);
    end

    // Bus outputs are decoded from the registered state. Reset therefore
    // clears the memory controls at once and does not wait for a clock edge.
    always_comb begin
        bus.i_gnt       = (state_q == IDLE) && fetch_win;
        bus.d_gnt       = (state_q == IDLE) && data_win;
        bus.i_done      = i_done_q;
        bus.d_done      = d_done_q;
        bus.i_rdata     = rdata_q;
        bus.d_rdata     = rdata_q;
        bus.busy        = (state_q == ACCESS);
        bus.mem_address = (state_q == ACCESS) ? addr_q  : '0;
        bus.mem_dataIn  = (state_q == ACCESS) ? wdata_q : '0;
        // The write commits on the edge that ends the final ACCESS cycle.
        bus.mem_wEn     = last_cycle && owner_d_q && we_q;
        dbg_state_o     = (state_q == ACCESS);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            owner_d_q <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            cnt_q     <= 4'd0;
            scnt_q    <= '0;
            rdata_q   <= '0;
            i_done_q  <= 1'b0;
            d_done_q  <= 1'b0;
        end else begin
            // Done flags are single-cycle pulses. They are raised only by the
            // final ACCESS cycle below.
            i_done_q <= 1'b0;
            d_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // While i_req is high, exactly one side is granted. If
                    // fetch did not win, data won, and fetch lost one more
                    // round.
                    if (!bus.i_req || fetch_win) begin
                        scnt_q <= '0;
                    end else if (scnt_q < SCNT_LIM) begin
                        scnt_q <= scnt_q + SCNT_W'(1);
                    end
                    if (fetch_win || data_win) begin
                        state_q   <= ACCESS;
                        owner_d_q <= data_win;
                        addr_q    <= data_win ? bus.d_addr : bus.i_addr;
                        wdata_q   <= data_win ? bus.d_wdata : '0;
                        we_q      <= data_win && bus.d_we;
                        cnt_q     <= 4'(WAIT_STATES);
                    end
                end
                ACCESS: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        // A store leaves the last read data untouched.
                        if (!we_q) begin
                            rdata_q <= bus.mem_memout;
                        end
                        if (owner_d_q) begin
                            d_done_q <= 1'b1;
                        end else begin
                            i_done_q <= 1'b1;
                        end
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Directed scenarios followed by a randomized phase. Expected values come
//   from a transaction-level reference model. It tracks the cycle in which
//   each access was granted and derives busy, done, write-enable and read
//   data from that cycle. A reference copy of memory is updated when each
//   access completes.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int WS = 1;
    localparam int SL = 2;

    logic clk = 1'b0;
    logic rst;
    logic dbg_state;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .WAIT_STATES(WS), .STARVE_LIMIT(SL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    // ---------------- memory model (64 words) ----------------
    logic [DW-1:0] mem [0:63];
    logic          pre_we;
    logic [5:0]    pre_addr;
    logic [DW-1:0] pre_data;

    assign bus.mem_memout = mem[bus.mem_address[5:0]];

    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (bus.mem_wEn) mem[bus.mem_address[5:0]] <= bus.mem_dataIn;
    end

    // ---------------- scoreboard / reference model ----------------
    int            vectors = 0;
    int            miscompares = 0;
    int            cyc;
    int            g_cyc;
    logic          g_d, g_we;
    logic [AW-1:0] g_addr;
    logic [DW-1:0] g_wdata;
    logic [DW-1:0] exp_rdata;
    int            scnt_m;
    logic [DW-1:0] ref_mem [0:63];

    // values captured at the last check point
    logic          o_ig, o_dg, o_id, o_dd, o_we;
    logic [DW-1:0] o_irdata, o_drdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        g_cyc     = -100;
        g_d       = 1'b0;
        g_we      = 1'b0;
        g_addr    = '0;
        g_wdata   = '0;
        exp_rdata = '0;
        scnt_m    = 0;
    endtask

    task automatic chk_all_zero(input string p);
        chk({p, "_i_gnt"},   bus.i_gnt, 0);
        chk({p, "_d_gnt"},   bus.d_gnt, 0);
        chk({p, "_i_done"},  bus.i_done, 0);
        chk({p, "_d_done"},  bus.d_done, 0);
        chk({p, "_i_rdata"}, bus.i_rdata, 0);
        chk({p, "_d_rdata"}, bus.d_rdata, 0);
        chk({p, "_addr"},    bus.mem_address, 0);
        chk({p, "_dataIn"},  bus.mem_dataIn, 0);
        chk({p, "_wEn"},     bus.mem_wEn, 0);
        chk({p, "_busy"},    bus.busy, 0);
        chk({p, "_state"},   dbg_state, 0);
    endtask

    // One clock cycle: check at negedge, update the model at posedge, and
    // return 1 time unit after posedge, ready for new inputs.
    task automatic tick();
        logic          bsy, dn, last, fw, dw, ir, dr, dwe;
        logic [AW-1:0] ia, da;
        logic [DW-1:0] dwd;
        @(negedge clk);
        ir = bus.i_req; dr = bus.d_req; dwe = bus.d_we;
        ia = bus.i_addr; da = bus.d_addr; dwd = bus.d_wdata;
        bsy  = (cyc >= g_cyc + 1) && (cyc <= g_cyc + 1 + WS);
        last = (cyc == g_cyc + 1 + WS);
        dn   = (cyc == g_cyc + 2 + WS);
        fw   = !bsy && ir && (!dr || scnt_m >= SL);
        dw   = !bsy && dr && !fw;
        chk("i_gnt",   bus.i_gnt, fw);
        chk("d_gnt",   bus.d_gnt, dw);
        chk("busy",    bus.busy, bsy);
        chk("i_done",  bus.i_done, dn && !g_d);
        chk("d_done",  bus.d_done, dn && g_d);
        chk("i_rdata", bus.i_rdata, exp_rdata);
        chk("d_rdata", bus.d_rdata, exp_rdata);
        chk("mem_wEn", bus.mem_wEn, last && g_d && g_we);
        chk("mem_address", bus.mem_address, bsy ? g_addr : '0);
        if (!bsy || (g_d && g_we))
            chk("mem_dataIn", bus.mem_dataIn, bsy ? g_wdata : '0);
        o_ig = bus.i_gnt; o_dg = bus.d_gnt; o_id = bus.i_done; o_dd = bus.d_done;
        o_we = bus.mem_wEn; o_irdata = bus.i_rdata; o_drdata = bus.d_rdata;
        @(posedge clk);
        if (last) begin
            if (g_d && g_we) ref_mem[g_addr[5:0]] = g_wdata;
            else exp_rdata = ref_mem[g_addr[5:0]];
        end
        if (!bsy) begin
            if (!ir || fw) scnt_m = 0;
            else if (scnt_m < SL) scnt_m = scnt_m + 1;
        end
        if (fw || dw) begin
            g_cyc   = cyc;
            g_d     = dw;
            g_we    = dw && dwe;
            g_addr  = dw ? da : ia;
            g_wdata = dw ? dwd : '0;
        end
        cyc++;
        #1;
    endtask

    // Called 1 unit after posedge: assert reset in the middle of the cycle.
    task automatic reset_mid(input string p);
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        chk_all_zero(p);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, grants, dones, coinc;
        logic [5:0] order;
        logic [DW-1:0] v;

        rst = 1'b1;
        pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        bus.i_req = 0; bus.i_addr = '0;
        bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;
        cyc = 0;
        model_reset();
        #2;
        chk_all_zero("por");

        // Preload memory while reset is held.
        @(posedge clk); #1;
        for (int i = 0; i < 64; i++) begin
            v = (i == 5) ? 32'hDEADBEEF : $urandom;
            pre_we = 1'b1; pre_addr = 6'(i); pre_data = v;
            ref_mem[i] = v;
            @(posedge clk); #1;
        end
        pre_we = 1'b0;
        rst = 1'b0;

        // Fetch read of address 5.
        bus.i_req = 1; bus.i_addr = 5;
        tick();
        chk("t1_i_gnt", o_ig, 1);
        bus.i_req = 0;
        repeat (3) tick();
        chk("t1_i_done", o_id, 1);
        chk("t1_i_rdata", o_irdata, 32'hDEADBEEF);

        // Store to 9, then load it back.
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 9; bus.d_wdata = 32'h12345678;
        tick();
        chk("t2_d_gnt", o_dg, 1);
        bus.d_req = 0; bus.d_we = 0;
        tick(); chk("t2_wEn_T1", o_we, 0);
        tick(); chk("t2_wEn_T2", o_we, 1);
        tick(); chk("t2_d_done", o_dd, 1);
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 9;
        tick();
        bus.d_req = 0;
        repeat (3) tick();
        chk("t2_ld_done", o_dd, 1);
        chk("t2_ld_rdata", o_drdata, 32'h12345678);

        // Arbitration with both requests held.
        bus.i_req = 1; bus.i_addr = 3;
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 7;
        n = 0; order = '0;
        for (int k = 0; k < 80 && n < 6; k++) begin
            tick();
            if (o_ig || o_dg) begin
                order = {order[4:0], o_dg};
                n++;
            end
        end
        chk("arb_count", n, 6);
        chk("arb_order", order, 6'b110110);
        bus.i_req = 0; bus.d_req = 0;
        repeat (WS + 2) tick();

        // Mid-cycle reset in the middle of a load access.
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 12;
        tick();
        bus.d_req = 0;
        reset_mid("rst_load");
        repeat (4) tick();

        // Reset in the middle of a store: the write must not commit.
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 20; bus.d_wdata = ~ref_mem[20];
        tick();
        chk("t5_d_gnt", o_dg, 1);
        bus.d_we = 0;
        reset_mid("rst_store");
        repeat (4) tick();
        chk("t5_mem_kept", mem[20], ref_mem[20]);
        chk("t5_state", dbg_state, 0);

        // Back-to-back loads with d_req held.
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 30;
        grants = 0; dones = 0; coinc = 0;
        for (int k = 0; k < 40 && grants < 3; k++) begin
            tick();
            if (o_dd) dones++;
            if (o_dg) begin
                grants++;
                if (o_dd) coinc++;
                bus.d_addr = 6'(30 + grants);
            end
        end
        bus.d_req = 0;
        for (int k = 0; k < WS + 2; k++) begin
            tick();
            if (o_dd) dones++;
        end
        chk("b2b_grants", grants, 3);
        chk("b2b_dones", dones, 3);
        chk("b2b_gnt_with_done", coinc, 2);

        // Randomized traffic.
        for (int k = 0; k < 500; k++) begin
            if (o_ig || !bus.i_req) begin
                bus.i_req  = 1'($urandom_range(0, 1));
                bus.i_addr = 32'($urandom_range(0, 63));
            end else if ($urandom_range(0, 15) == 0) begin
                bus.i_addr = 32'($urandom_range(0, 63));
            end
            if (o_dg || !bus.d_req) begin
                bus.d_req   = 1'($urandom_range(0, 1));
                bus.d_we    = 1'($urandom_range(0, 1));
                bus.d_addr  = 32'($urandom_range(0, 63));
                bus.d_wdata = $urandom;
            end else if ($urandom_range(0, 15) == 0) begin
                bus.d_req = 1'b0;
            end
            tick();
        end
        bus.i_req = 0; bus.d_req = 0;
        repeat (WS + 3) tick();
        for (int i = 0; i < 64; i++) chk("final_mem", mem[i], ref_mem[i]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
